// File: rtl/sense_scan_scheduler.sv
// sense_scan_scheduler: shares one ADC across cell, current and temperature channels,
// flagging each result against its threshold and failing safe on a silent ADC.
module sense_scan_scheduler #(
  parameter int NUM_CELLS   = 4,
  parameter int ADC_BITS    = 12,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter int SCAN_GAP    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [ADC_BITS-1:0]              ov_thresh,
  input  logic [ADC_BITS-1:0]              uv_thresh,
  input  logic [ADC_BITS-1:0]              cur_thresh,
  input  logic [ADC_BITS-1:0]              temp_thresh,
  output logic [$clog2(NUM_CELLS+2)-1:0]   adc_mux_sel,
  output logic                             adc_start,
  input  logic                             adc_done,
  input  logic [ADC_BITS-1:0]              adc_data,
  output logic [NUM_CELLS-1:0]             cell_overvoltage,
  output logic [NUM_CELLS-1:0]             cell_undervoltage,
  output logic                             current_overlimit,
  output logic                             temp_overlimit,
  output logic                             adc_timeout,
  output logic                             scan_done,
  output logic                             busy
);
  localparam int CHW = $clog2(NUM_CELLS+2);
  localparam int M1 = SETTLE_CYC > TIMEOUT_CYC ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int MAXC = M1 > SCAN_GAP ? M1 : SCAN_GAP;
  localparam int CW = $clog2(MAXC+1);
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, GAP} state_t;
  state_t state, state_nx;
  logic [CHW-1:0] ch, ch_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [NUM_CELLS-1:0] ov_nx, uv_nx;
  logic cur_nx, tmp_nx, tout_nx, hit, fin, last_ch;
  assign hit = state == WAIT && adc_done;
  // a conversion finishes on done or on its last allowed WAIT cycle; done wins the tie
  assign fin = state == WAIT && (adc_done || cnt == CW'(TIMEOUT_CYC-1));
  assign last_ch = ch == CHW'(NUM_CELLS+1);
  assign adc_start = state == WAIT && cnt == '0;
  assign scan_done = state == GAP && cnt == '0;
  assign busy = state != IDLE;
  assign adc_mux_sel = ch;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ch <= '0;
      cnt <= '0;
      cell_overvoltage <= '0;
      cell_undervoltage <= '0;
      current_overlimit <= 1'b0;
      temp_overlimit <= 1'b0;
      adc_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      ch <= ch_nx;
      cnt <= cnt_nx;
      cell_overvoltage <= ov_nx;
      cell_undervoltage <= uv_nx;
      current_overlimit <= cur_nx;
      temp_overlimit <= tmp_nx;
      adc_timeout <= tout_nx;
    end
  always_comb begin
    state_nx = state;
    ch_nx = ch;
    cnt_nx = cnt + CW'(1);
    ov_nx = cell_overvoltage;
    uv_nx = cell_undervoltage;
    cur_nx = current_overlimit;
    tmp_nx = temp_overlimit;
    tout_nx = adc_timeout;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (enable) begin
          state_nx = SETTLE;
          ch_nx = '0;
        end
      end
      SETTLE: if (cnt == CW'(SETTLE_CYC-1)) begin
        state_nx = WAIT;
        cnt_nx = '0;
      end
      WAIT: if (fin) begin
        state_nx = last_ch ? GAP : SETTLE;
        ch_nx = last_ch ? ch : ch + CHW'(1);
        cnt_nx = '0;
      end
      GAP: if (cnt == CW'(SCAN_GAP-1)) begin
        state_nx = enable ? SETTLE : IDLE;
        ch_nx = '0;
        cnt_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
    // a timed-out channel reports every flag it owns as set
    if (fin) begin
      for (int i = 0; i < NUM_CELLS; i++)
        if (ch == CHW'(i)) begin
          ov_nx[i] = !hit || adc_data > ov_thresh;
          uv_nx[i] = !hit || adc_data < uv_thresh;
        end
      if (ch == CHW'(NUM_CELLS)) cur_nx = !hit || adc_data > cur_thresh;
      if (last_ch) tmp_nx = !hit || adc_data > temp_thresh;
      tout_nx = adc_timeout || !hit;
    end
  end
endmodule

// File: tb/tb_sense_scan_scheduler.sv
// tb_sense_scan_scheduler: table vectors, corner sequences and random scans checked
// against a per-scan flag model and an ADC responder that tracks settle timing.
module tb_sense_scan_scheduler;
  localparam int NC = 4, AB = 12, SC = 8, TO = 255, SG = 16;
  logic clk = 0;
  logic rst_n, enable;
  logic [AB-1:0] ov_thresh, uv_thresh, cur_thresh, temp_thresh, adc_data;
  logic [2:0] adc_mux_sel;
  logic adc_start, adc_done, current_overlimit, temp_overlimit, adc_timeout, scan_done, busy;
  logic [NC-1:0] cell_overvoltage, cell_undervoltage;
  always #5 clk = ~clk;
  sense_scan_scheduler #(.NUM_CELLS(NC), .ADC_BITS(AB), .SETTLE_CYC(SC), .TIMEOUT_CYC(TO), .SCAN_GAP(SG)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ov_thresh(ov_thresh), .uv_thresh(uv_thresh), .cur_thresh(cur_thresh), .temp_thresh(temp_thresh),
    .adc_mux_sel(adc_mux_sel), .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .cell_overvoltage(cell_overvoltage), .cell_undervoltage(cell_undervoltage),
    .current_overlimit(current_overlimit), .temp_overlimit(temp_overlimit),
    .adc_timeout(adc_timeout), .scan_done(scan_done), .busy(busy)
  );
  typedef struct {
    logic [5:0][11:0] d;
    logic [11:0] ovt, uvt, ct, tt;
    logic [3:0] ov, uv;
    logic c, t;
  } vec_t;
  vec_t tbl[5];
  int total = 0, bad = 0;
  int ncyc = 0, starts = 0, settle_err = 0, settle_at = 0, k = 0, cur_ch = 0;
  bit active = 0;
  logic [2:0] settle_mux = 0;
  int q[$];
  int dly[6];
  logic [11:0] dat[6];
  logic rsp_done = 0, spur = 0;
  logic [11:0] rsp_data = 0, spur_data = 0;
  logic [3:0] e_ov, e_uv;
  logic e_c, e_t, e_to;
  logic [9:0] sv;
  assign adc_done = rsp_done | spur;
  assign adc_data = spur ? spur_data : rsp_data;
  // ADC model: replies dly[ch] WAIT cycles after start, silent when dly >= TO
  always @(negedge clk) begin
    ncyc++;
    rsp_done = 0;
    if (!busy) begin
      active = 0;
      settle_at = ncyc + 1;
    end
    if (ncyc == settle_at) settle_mux = adc_mux_sel;
    if (adc_start) begin
      starts++;
      q.push_back(int'(adc_mux_sel));
      if (ncyc - settle_at != SC || adc_mux_sel != settle_mux) settle_err++;
      active = 1;
      k = 0;
      cur_ch = int'(adc_mux_sel);
    end
    if (active) begin
      if (int'(adc_mux_sel) != cur_ch) settle_err++;
      if (k == dly[cur_ch]) begin
        rsp_done = 1;
        rsp_data = dat[cur_ch];
        active = 0;
        settle_at = ncyc + 1;
      end else if (k == TO - 1) begin
        active = 0;
        settle_at = ncyc + 1;
      end
      k++;
    end
    if (scan_done) settle_at = ncyc + SG;
  end
  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask
  function automatic void model();
    bit s;
    for (int i = 0; i < NC; i++) begin
      s = dly[i] >= TO;
      e_ov[i] = s || dat[i] > ov_thresh;
      e_uv[i] = s || dat[i] < uv_thresh;
      e_to |= s;
    end
    s = dly[4] >= TO;
    e_c = s || dat[4] > cur_thresh;
    e_to |= s;
    s = dly[5] >= TO;
    e_t = s || dat[5] > temp_thresh;
    e_to |= s;
  endfunction
  task automatic set_vec(input int i);
    ov_thresh = tbl[i].ovt;
    uv_thresh = tbl[i].uvt;
    cur_thresh = tbl[i].ct;
    temp_thresh = tbl[i].tt;
    for (int j = 0; j < 6; j++) begin
      dat[j] = tbl[i].d[j];
      dly[j] = 3;
    end
    e_ov = tbl[i].ov;
    e_uv = tbl[i].uv;
    e_c = tbl[i].c;
    e_t = tbl[i].t;
  endtask
  task automatic check_flags(input string nm);
    chk({nm, " ov"}, int'(cell_overvoltage), int'(e_ov));
    chk({nm, " uv"}, int'(cell_undervoltage), int'(e_uv));
    chk({nm, " cur"}, int'(current_overlimit), int'(e_c));
    chk({nm, " temp"}, int'(temp_overlimit), int'(e_t));
    chk({nm, " timeout"}, int'(adc_timeout), int'(e_to));
  endtask
  task automatic scan(input string nm, input bit drop);
    int n = 0, s0 = starts, e0 = settle_err, seq = 0;
    q.delete();
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (drop && busy && adc_mux_sel == 3'd1) enable = 0;
      if (scan_done) break;
    end
    chk({nm, " scan_done"}, int'(scan_done), 1);
    chk({nm, " starts"}, starts - s0, 6);
    for (int i = 0; i < q.size() && i < 6; i++) seq |= q[i] << (3 * i);
    chk({nm, " mux seq"}, seq, 32'o543210);
    chk({nm, " settle/mux"}, settle_err - e0, 0);
    check_flags(nm);
  endtask
  initial begin
    int n, s;
    tbl[0] = '{d:{12'h900, 12'h801, 12'h400, 12'h3FF, 12'hE01, 12'hE00}, ovt:12'hE00, uvt:12'h400, ct:12'h800, tt:12'h900, ov:4'b0010, uv:4'b0100, c:1'b1, t:1'b0};
    tbl[1] = '{d:{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000}, ovt:12'hE00, uvt:12'h400, ct:12'h800, tt:12'h900, ov:4'b0000, uv:4'b1111, c:1'b0, t:1'b0};
    tbl[2] = '{d:{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, ovt:12'hE00, uvt:12'h400, ct:12'h800, tt:12'h900, ov:4'b1111, uv:4'b0000, c:1'b1, t:1'b1};
    tbl[3] = '{d:{12'h901, 12'h800, 12'hE01, 12'h400, 12'h3FF, 12'hE00}, ovt:12'hE00, uvt:12'h400, ct:12'h800, tt:12'h900, ov:4'b1000, uv:4'b0010, c:1'b0, t:1'b1};
    tbl[4] = '{d:{12'hFFF, 12'h001, 12'h100, 12'h101, 12'h0FF, 12'h000}, ovt:12'h100, uvt:12'h100, ct:12'h000, tt:12'hFFE, ov:4'b0100, uv:4'b0011, c:1'b1, t:1'b1};
    rst_n = 0;
    enable = 0;
    e_to = 0;
    set_vec(0);
    repeat (3) @(negedge clk);
    chk("reset flags", int'({cell_overvoltage, cell_undervoltage, current_overlimit, temp_overlimit, adc_timeout}), 0);
    chk("reset pulses", int'({adc_start, scan_done, busy}), 0);
    chk("reset mux", int'(adc_mux_sel), 0);
    rst_n = 1;
    repeat (50) @(negedge clk);
    chk("idle starts", starts, 0);
    chk("idle busy", int'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      set_vec(i);
      enable = 1;
      scan($sformatf("vec%0d", i), 0);
    end
    spur = 1;
    spur_data = 12'h000;
    @(negedge clk);
    spur = 0;
    check_flags("gap spur");
    sv = {e_ov, e_uv, e_c, e_t};
    set_vec(0);
    n = 0;
    while (adc_mux_sel != 3'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    spur = 1;
    spur_data = 12'hFFF;
    @(negedge clk);
    spur = 0;
    chk("settle spur", int'({cell_overvoltage, cell_undervoltage, current_overlimit, temp_overlimit}), int'(sv));
    scan("vec0b", 0);
    set_vec(0);
    dly[2] = TO - 1;
    scan("coincident", 0);
    set_vec(0);
    dly[4] = 9999;
    e_c = 1;
    e_to = 1;
    scan("timeout", 0);
    set_vec(3);
    scan("after timeout", 0);
    set_vec(1);
    scan("drop", 1);
    n = 0;
    do begin
      if (busy) n++;
      @(negedge clk);
    end while (busy && n < 100);
    chk("gap length", n, SG);
    chk("drop idle busy", int'(busy), 0);
    s = starts;
    repeat (30) @(negedge clk);
    chk("drop no restart", starts - s, 0);
    for (int r = 0; r < 8; r++) begin
      ov_thresh = 12'($urandom);
      uv_thresh = 12'($urandom);
      cur_thresh = 12'($urandom);
      temp_thresh = 12'($urandom);
      for (int j = 0; j < 6; j++) begin
        dat[j] = 12'($urandom);
        if ($urandom_range(0, 3) == 0)
          dat[j] = j == 5 ? temp_thresh : j == 4 ? cur_thresh : $urandom_range(0, 1) ? ov_thresh : uv_thresh;
        n = $urandom_range(0, 19);
        dly[j] = n == 0 ? 9999 : n == 1 ? TO - 1 : $urandom_range(0, 5);
      end
      model();
      enable = 1;
      scan($sformatf("rand%0d", r), 0);
    end
    set_vec(0);
    n = 0;
    while (!(adc_start && adc_mux_sel == 3'd3) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reach ch3 wait", int'(adc_start && adc_mux_sel == 3'd3), 1);
    #2 rst_n = 0;
    #1;
    chk("async rst flags", int'({cell_overvoltage, cell_undervoltage, current_overlimit, temp_overlimit, adc_timeout}), 0);
    chk("async rst pulses", int'({adc_start, scan_done, busy}), 0);
    chk("async rst mux", int'(adc_mux_sel), 0);
    @(negedge clk);
    rst_n = 1;
    e_to = 0;
    scan("post reset", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sense_scan_scheduler.md
SENSE_SCAN_SCHEDULER -- requirements
Module: sense_scan_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_CELLS, 4, number of cell voltage channels.
- ADC_BITS, 12, ADC result width.
- SETTLE_CYC, 8, mux settle cycles before each conversion start (>=1).
- TIMEOUT_CYC, 255, maximum WAIT cycles allowed per conversion (>=1).
- SCAN_GAP, 16, idle cycles between consecutive scans (>=1).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset: asynchronous, active-low.
- enable, in, 1, scanning enabled.
- ov_thresh / uv_thresh / cur_thresh / temp_thresh, in, ADC_BITS, compare thresholds.
- adc_mux_sel, out, $clog2(NUM_CELLS+2), ADC channel select.
- adc_start, out, 1, conversion start pulse.
- adc_done, in, 1, conversion complete strobe.
- adc_data, in, ADC_BITS, result; valid only with adc_done.
- cell_overvoltage / cell_undervoltage, out, NUM_CELLS, per-cell flags.
- current_overlimit / temp_overlimit, out, 1, channel flags.
- adc_timeout, out, 1, sticky ADC no-response flag.
- scan_done, out, 1, one-cycle end-of-scan pulse.
- busy, out, 1, high in every state except IDLE.

Function
REQ-003 The block SHALL share one ADC across NUM_CELLS+2 channels: 0..NUM_CELLS-1 are cells, NUM_CELLS is current, NUM_CELLS+1 is temperature. Each scan SHALL visit them in ascending order.
REQ-004 FSM states SHALL be IDLE, SETTLE, WAIT, GAP.
REQ-005 IDLE -> SETTLE with channel=0 SHALL occur on the first clk edge at which enable=1.
REQ-006 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to WAIT.
REQ-007 adc_start SHALL be high for exactly the first WAIT cycle of each conversion and low at all other times.
REQ-008 adc_mux_sel SHALL equal the current channel and SHALL be stable from SETTLE entry until WAIT exit.
REQ-009 adc_done SHALL be accepted in any WAIT cycle, including the adc_start cycle. adc_done SHALL be ignored in IDLE, SETTLE and GAP.
REQ-010 On an accepted adc_done, the channel flag SHALL update on that same edge:
- cell OV = adc_data > ov_thresh.
- cell UV = adc_data < uv_thresh.
- current = adc_data > cur_thresh.
- temp = adc_data > temp_thresh.
- All compares are unsigned and strict; equality SHALL NOT flag.
REQ-011 Each flag SHALL hold its value until the same channel is converted again.
REQ-012 If TIMEOUT_CYC WAIT cycles elapse without adc_done:
- adc_timeout SHALL set and stay set until reset.
- The channel's flag(s) SHALL be set to 1 (fail-safe); a timed-out cell sets both OV and UV.
- The channel SHALL advance as if done had arrived.
- If adc_done arrives in the same cycle the timeout is reached, done SHALL win.
REQ-013 After the last channel completes, the FSM SHALL enter GAP and assert scan_done for one cycle, the first GAP cycle.
REQ-014 GAP SHALL last SCAN_GAP cycles, then go to SETTLE with channel=0 if enable=1, else to IDLE.
REQ-015 enable SHALL be sampled only in IDLE and on GAP exit. Deasserting enable mid-scan SHALL NOT abort the scan.
REQ-016 Threshold inputs SHALL be sampled at compare time; no shadowing.

Reset
REQ-017 On rst_n low, the following SHALL clear immediately (asynchronously), including mid-conversion:
- FSM to IDLE; channel, adc_mux_sel and all counters to 0.
- adc_start, all flags, adc_timeout, scan_done and busy to 0.
REQ-018 After rst_n release, no adc_start SHALL occur before enable is sampled high.

Verification
REQ-019 The bench SHALL cover the following scenarios (all use NUM_CELLS=4, ov=0xE00, uv=0x400, cur=0x800, temp=0x900):
- Reset: all outputs 0, busy=0; with enable held 0 for 50 cycles, no adc_start occurs.
- Scan with ADC replying 3 cycles after start, data cell0=0xE00, cell1=0xE01, cell2=0x3FF, cell3=0x400, cur=0x801, temp=0x900:
  - expect OV=0010, UV=0100, current_overlimit=1, temp_overlimit=0;
  - adc_mux_sel sequence 0..5;
  - exactly 6 adc_start pulses;
  - each adc_start exactly SETTLE_CYC cycles after its SETTLE entry;
  - one scan_done.
- ADC silent on channel 4: after 255 WAIT cycles adc_timeout=1 and current_overlimit=1, then channel 5 converts normally; adc_timeout still 1 after the next scan.
- enable dropped during channel 1: the scan completes all 6 channels, scan_done pulses, GAP lasts 16 cycles, then IDLE with busy=0.
- Spurious adc_done in SETTLE and GAP: no flag change. adc_done coincident with the timeout cycle: data is used and adc_timeout stays 0.
- rst_n asserted mid-WAIT on channel 3 with flags set: all outputs 0 before the next clk edge; after release with enable=1, the scan restarts at channel 0.
